// File: rtl/drum_pkg.sv
// drum_pkg: shared defaults and the per-operand shift helper for the DRUM denormalizer.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

package drum_pkg;

  localparam int DRUM_WIDTH       = 16;
  localparam int DRUM_ROUND_WIDTH = 4;
  localparam int DRUM_LOG2_WIDTH  = 4;

  // An operand whose leading one sits below the kept window needs no shift back.
  function automatic int unsigned drum_shift(input int unsigned k, input int unsigned round_width);
    return (k > round_width - 1) ? (k - (round_width - 1)) : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shift_right_left.sv
// barrel_shift_right_left: combinational logarithmic left barrel shifter.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module barrel_shift_right_left #(
  parameter int DATA_W  = 32,
  parameter int SHIFT_W = 5
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHIFT_W-1:0] i_shamt,
  output logic [DATA_W-1:0]  o_data
);

  logic [DATA_W-1:0] w_stage [0:SHIFT_W];

  assign w_stage[0] = i_data;

  for (genvar g = 0; g < SHIFT_W; g++) begin : g_stage
    assign w_stage[g+1] = i_shamt[g] ? (w_stage[g] << (2**g)) : w_stage[g];
  end

  assign o_data = w_stage[SHIFT_W];

endmodule

`default_nettype wire

// File: rtl/drum_denorm_shifter.sv
// drum_denorm_shifter: two-stage valid/ready denormalizer, out = prod << (sa+sb).
// Optional macro DRUM_DENORM_SIGNED_EN adds in_sign and two's-complement output. Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module drum_denorm_shifter
  import drum_pkg::*;
#(
  parameter int WIDTH       = DRUM_WIDTH,
  parameter int ROUND_WIDTH = DRUM_ROUND_WIDTH,
  parameter int LOG2_WIDTH  = DRUM_LOG2_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*ROUND_WIDTH-1:0] in_prod,
  input  logic [LOG2_WIDTH-1:0]    in_ka,
  input  logic [LOG2_WIDTH-1:0]    in_kb,
  input  logic                     in_zero,
`ifdef DRUM_DENORM_SIGNED_EN
  input  logic                     in_sign,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_result
);

  localparam int PW = 2 * ROUND_WIDTH;
  localparam int OW = 2 * WIDTH;
  localparam int SW = LOG2_WIDTH + 1;

  logic [LOG2_WIDTH-1:0] w_sa;
  logic [LOG2_WIDTH-1:0] w_sb;
  logic [SW-1:0]         w_shamt;
  logic                  w_s1_load;
  logic                  w_s2_load;
  logic [OW-1:0]         w_shifted;

  logic                  r_s1_valid;
  logic [PW-1:0]         r_s1_prod;
  logic [SW-1:0]         r_s1_shamt;
  logic                  r_s1_zero;
  logic                  r_s1_sign;
  logic                  r_out_valid;
  logic [OW-1:0]         r_out_result;
  logic                  w_in_sign;

`ifdef DRUM_DENORM_SIGNED_EN
  assign w_in_sign = in_sign;
`else
  assign w_in_sign = 1'b0;
`endif

  assign w_sa    = LOG2_WIDTH'(drum_shift(32'(in_ka), ROUND_WIDTH));
  assign w_sb    = LOG2_WIDTH'(drum_shift(32'(in_kb), ROUND_WIDTH));
  assign w_shamt = SW'(w_sa) + SW'(w_sb);

  // S1 may refill in the same cycle S2 drains it, so ready looks through to out_ready.
  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_shamt <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_sign  <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_prod  <= in_prod;
        r_s1_shamt <= w_shamt;
        r_s1_zero  <= in_zero;
        r_s1_sign  <= w_in_sign;
      end
    end
  end

  barrel_shift_right_left #(
    .DATA_W  (OW),
    .SHIFT_W (SW)
  ) u_shift (
    .i_data  (OW'(r_s1_prod)),
    .i_shamt (r_s1_shamt),
    .o_data  (w_shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (r_s1_zero) begin
          r_out_result <= '0;
        end else if (r_s1_sign) begin
          r_out_result <= -w_shifted;
        end else begin
          r_out_result <= w_shifted;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;

endmodule

`default_nettype wire

// File: tb/tb_drum_denorm_shifter.sv
// tb_drum_denorm_shifter: scoreboard bench for drum_denorm_shifter.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_drum_denorm_shifter;

  localparam int OW = 32;
  localparam int RW = 4;

  typedef struct {
    logic [7:0] prod;
    logic [3:0] ka;
    logic [3:0] kb;
    logic       zero;
    logic       sign;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_prod = '0;
  logic [3:0]    in_ka = '0;
  logic [3:0]    in_kb = '0;
  logic          in_zero = 1'b0;
  logic          in_sign = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_result;

  int checks = 0;
  int failures = 0;

  beat_t         stim_q[$];
  logic [OW-1:0] exp_q[$];

  always #5 clk = ~clk;

  drum_denorm_shifter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_ka      (in_ka),
    .in_kb      (in_kb),
    .in_zero    (in_zero),
`ifdef DRUM_DENORM_SIGNED_EN
    .in_sign    (in_sign),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  function automatic logic [OW-1:0] model(input beat_t b);
    int sh;
    logic [OW-1:0] r;
    sh = ((int'(b.ka) > RW - 1) ? int'(b.ka) - (RW - 1) : 0) +
         ((int'(b.kb) > RW - 1) ? int'(b.kb) - (RW - 1) : 0);
    r = OW'(b.prod) << sh;
    if (b.zero) r = '0;
    else if (b.sign) r = -r;
    return r;
  endfunction

  function automatic beat_t mk(input logic [7:0] p, input logic [3:0] a, input logic [3:0] b,
                               input logic z, input logic s);
    beat_t t;
    t.prod = p; t.ka = a; t.kb = b; t.zero = z; t.sign = s;
    return t;
  endfunction

  // Entered and left at posedge+1; mode 0 ready=1, 1 ready=1,0,0 repeating, 2 random.
  task automatic run_sb(input int mode, input string tag, output int cycles);
    int cyc = 0;
    logic held_v = 1'b0;
    logic [OW-1:0] held = '0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 500) begin
      if (stim_q.size() > 0) begin
        in_valid = 1'b1;
        in_prod = stim_q[0].prod; in_ka = stim_q[0].ka; in_kb = stim_q[0].kb;
        in_zero = stim_q[0].zero; in_sign = stim_q[0].sign;
      end else begin
        in_valid = 1'b0;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== held) begin
          failures++;
          $display("FAIL %s_stall_stable: got valid=%b result=%h, need valid=1 result=%h",
                   tag, out_valid, out_result, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s_extra_result: got result=%h, need no result", tag, out_result);
        end else begin
          if (out_result !== exp_q[0]) begin
            failures++;
            $display("FAIL %s_result: got %h, need %h", tag, out_result, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        held_v = 1'b0;
      end else if (out_valid) begin
        held_v = 1'b1;
        held = out_result;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(stim_q[0]));
        void'(stim_q.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (stim_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d beats and %0d results pending, need 0 and 0",
               tag, stim_q.size(), exp_q.size());
      stim_q.delete();
      exp_q.delete();
    end
    cycles = cyc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b, need 0", out_valid);
    end
    checks++;
    if (out_result !== '0) begin
      failures++; $display("FAIL reset_out_result: got %h, need 0", out_result);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b, need 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int n;
    in_valid = 1'b1; in_prod = 8'h5B; in_ka = 4'd10; in_kb = 4'd7; in_zero = 1'b0; in_sign = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL latency: got %0d cycles, need 2", n);
    end
    checks++;
    if (out_result !== 32'h0002D800) begin
      failures++; $display("FAIL latency_result: got %h, need 0002d800", out_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int c;
    stim_q.push_back(mk(8'h0F, 4'd2, 4'd3, 1'b0, 1'b0));
    stim_q.push_back(mk(8'hFF, 4'd2, 4'd3, 1'b1, 1'b0));
    stim_q.push_back(mk(8'hFF, 4'd15, 4'd15, 1'b1, 1'b0));
    run_sb(0, "zero", c);
  endtask

  task automatic test_backpressure;
    int c;
    for (int i = 0; i < 8; i++)
      stim_q.push_back(mk(8'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0));
    run_sb(1, "backpressure", c);
  endtask

  task automatic test_back_to_back;
    int c;
    for (int i = 0; i < 8; i++)
      stim_q.push_back(mk(8'(i * 37 + 1), 4'(i + 4), 4'(15 - i), 1'b0, 1'b0));
    run_sb(0, "back_to_back", c);
    checks++;
    if (c != 10) begin
      failures++; $display("FAIL back_to_back_cycles: got %0d, need 10", c);
    end
  endtask

  task automatic test_random;
    int c;
    for (int i = 0; i < 24; i++)
      stim_q.push_back(mk(8'($urandom), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 5) == 0), 1'b0));
    run_sb(2, "random", c);
  endtask

  task automatic test_max_shift;
    int c;
    stim_q.push_back(mk(8'hFF, 4'd15, 4'd15, 1'b0, 1'b0));
    run_sb(0, "max_shift", c);
  endtask

  task automatic test_reset_flight;
    int seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_prod = 8'h33; in_ka = 4'd6; in_kb = 4'd6; in_zero = 1'b0; in_sign = 1'b0;
    @(posedge clk); #1;
    in_prod = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== '0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b result=%h, need 0 and 0", out_valid, out_result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL flight_discard: got %0d results after reset, need 0", seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL flight_in_ready: got %b, need 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

`ifdef DRUM_DENORM_SIGNED_EN
  task automatic test_signed;
    int c;
    stim_q.push_back(mk(8'h01, 4'd3, 4'd3, 1'b0, 1'b1));
    stim_q.push_back(mk(8'h5B, 4'd10, 4'd7, 1'b0, 1'b1));
    stim_q.push_back(mk(8'hFF, 4'd9, 4'd9, 1'b1, 1'b1));
    stim_q.push_back(mk(8'h7A, 4'd12, 4'd2, 1'b0, 1'b0));
    run_sb(1, "signed", c);
  endtask
`endif

  initial begin
    test_reset;
    test_latency;
    test_zero;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_max_shift;
`ifdef DRUM_DENORM_SIGNED_EN
    test_signed;
`endif
    test_reset_flight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
